mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Arbiter and sequencer for the single shared asynchronous SRAM port of the discrete-transistor RV523 core. Two requesters share the port: instruction fetch (port 0, read-only) and load/store (port 1, read/write). The block accepts one request at a time and drives the SRAM control strobes for a fixed number of wait states, then returns a one-cycle acknowledge with registered read data. Round-robin on contention keeps state to a handful of flip-flops, which matters because every bit costs discrete NMOS/PMOS devices.

## Interface
- `AW`, default 16: SRAM address width.
- `DW`, default 32: data width.
- `WAIT`, default 2: SRAM access cycles minus one; legal range 0..7.

Clock and reset: one clock; reset is synchronous and active-high.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous active-high reset.
- `if_req`  in  1  fetch request; held until `if_ack`.
- `if_addr`  in  AW  fetch address; stable while `if_req`.
- `if_ack`  out  1  one-cycle fetch completion.
- `ls_req`  in  1  load/store request; held until `ls_ack`.
- `ls_we`  in  1  1 = write, 0 = read; stable while `ls_req`.
- `ls_addr`  in  AW  load/store address.
- `ls_wdata`  in  DW  write data.
- `ls_ack`  out  1  one-cycle load/store completion.
- `rdata`  out  DW  registered read data; valid in the ack cycle.
- `mem_cs`  out  1  SRAM chip select.
- `mem_oe`  out  1  SRAM output enable (reads).
- `mem_we`  out  1  SRAM write enable (writes).
- `mem_addr`  out  AW  SRAM address.
- `mem_wdata`  out  DW  SRAM write data.
- `mem_rdata`  in  DW  SRAM read data.

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE: if neither request is set, stay. If exactly one is set, grant it. If both are set, grant the port not in `last_grant`. On grant, latch the port, `we` (0 for fetch), address and wdata. Load the wait counter with `WAIT`, then go to ACCESS.
- ACCESS:
  - `mem_cs`=1, `mem_addr`/`mem_wdata` come from the latched values.
  - Reads drive `mem_oe`=1; writes drive `mem_we`=1 for every ACCESS cycle.
  - Counter decrements each cycle. When the counter is 0: capture `mem_rdata` into `rdata` on reads (`rdata` is unchanged on writes), update `last_grant`, go to DONE.
- DONE: assert the granted port's ack for exactly one cycle, strobes low, then go to IDLE.
- Requester rule: in the cycle after its ack, `req` is either low or a new transaction. The arbiter re-arbitrates in that IDLE cycle.
- Request inputs sampled in ACCESS or DONE are ignored; a pending request waits.
- Reset state: FSM=IDLE, `last_grant`=fetch (load/store wins the first tie), counter=0. All outputs are 0: `if_ack`, `ls_ack`, `rdata`, `mem_cs`/`oe`/`we`, `mem_addr`, `mem_wdata`.
- Reset mid-ACCESS or mid-DONE: all strobes drop the next cycle, no ack is issued, and the transaction is abandoned.
- `mem_addr`/`mem_wdata` hold their last value in IDLE/DONE (no extra toggling); strobes are 0 there.

## Timing
- Request first seen in IDLE at cycle t:
  - ACCESS spans cycles t+1 .. t+1+WAIT.
  - Ack and valid `rdata` at cycle t+2+WAIT.
  - Next grant no earlier than t+3+WAIT.
- With `WAIT`=2: ack at t+4, and the port is busy for 4 cycles per transaction.
- `WAIT`=0: a single ACCESS cycle, ack at t+2.
- All outputs are registered; there is no combinational path from any `req` to a strobe or ack.
- Back-to-back contention alternates strictly: the peak throughput of one requester under full contention is one access per 2×(WAIT+3) cycles.

## Structure
- Shared package `rv523_pkg`:
  - FSM state enum (IDLE/ACCESS/DONE, 2-bit).
  - Port index constants `PORT_IF`=0, `PORT_LS`=1.
  - Default `WAIT` constant.
- One sub-module: `mem_wait_counter`. It is a 3-bit loadable down-counter with a `load` input, a `zero` flag, and the same `clk`/`rst`.
- The arbiter FSM, latches and output registers stay in `mem_port_arbiter`.

## Test plan
- Single fetch, `WAIT`=2:
  - Stimulus: `if_req`=1, `if_addr`=0x0040 at t, `mem_rdata`=0xDEADBEEF.
  - Required: `mem_cs`/`oe`=1 for t+1..t+3, `if_ack`=1 and `rdata`=0xDEADBEEF at t+4 only, `mem_we` never 1.
- Store:
  - Stimulus: `ls_req`=1, `ls_we`=1, addr 0x1000, wdata 0x12345678.
  - Required: `mem_we`=1 for 3 cycles with those addr/data, `mem_oe`=0, `ls_ack` at t+4, `rdata` unchanged.
- Simultaneous requests from reset:
  - Stimulus: both held high continuously.
  - Required: grant order LS, IF, LS, IF; acks at t+4, t+9, t+14, t+19.
- Reset mid-access:
  - Stimulus: `rst` asserted in the second ACCESS cycle.
  - Required: next cycle all strobes 0, no ack, FSM IDLE; a fresh fetch afterwards completes normally.
- `WAIT`=0, back-to-back fetches at new addresses each ack:
  - Required: ack every 3 cycles, with `mem_cs` high for 1 cycle per access.

Source files
------------

// File: rtl/rv523_pkg.sv
// Shared definitions for the RV523 memory-port logic: arbiter FSM encoding,
// requester port indices and the default SRAM wait-state count.
package rv523_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } arb_state_e;

   localparam logic PORT_IF = 1'b0;
   localparam logic PORT_LS = 1'b1;

   localparam int WAIT_DEFAULT = 2;

endpackage

// File: rtl/mem_wait_counter.sv
// 3-bit loadable down-counter that times the SRAM access window.
// It stops at zero, so it idles at 0 between transactions.
module mem_wait_counter (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic [2:0] load_val,
   output logic       zero
);

   logic [2:0] count_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= 3'd0;
      end else if (load) begin
         count_q <= load_val;
      end else if (count_q != 3'd0) begin
         count_q <= count_q - 3'd1;
      end
   end

   assign zero = (count_q == 3'd0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter and strobe sequencer for the single shared SRAM port,
// serving instruction fetch (read-only) and load/store (read/write).
module mem_port_arbiter
   import rv523_pkg::*;
#(
   parameter int AW   = 16,
   parameter int DW   = 32,
   parameter int WAIT = WAIT_DEFAULT
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic          if_ack,
   input  logic          ls_req,
   input  logic          ls_we,
   input  logic [AW-1:0] ls_addr,
   input  logic [DW-1:0] ls_wdata,
   output logic          ls_ack,
   output logic [DW-1:0] rdata,
   output logic          mem_cs,
   output logic          mem_oe,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);

   // Handshake: a requester raises req with stable address/data and holds it
   // until its one-cycle ack; in the cycle after ack, req is low or a new
   // transaction. Requests are only sampled in IDLE, so ones arriving during
   // ACCESS/DONE simply wait.

   // Legal WAIT is 0..7; only the low three bits reach the counter.
   localparam logic [2:0] WAIT_L = 3'(WAIT);

   arb_state_e    state_q, state_d;
   logic          last_grant_q, last_grant_d;
   logic          port_q, port_d;
   logic          we_q, we_d;
   logic [AW-1:0] addr_d;
   logic [DW-1:0] wdata_d;
   logic          cs_d, oe_d, wes_d;
   logic          if_ack_d, ls_ack_d;
   logic          rdata_en;
   logic          cnt_load, cnt_zero;

   mem_wait_counter u_wait_counter (
      .clk      (clk),
      .rst      (rst),
      .load     (cnt_load),
      .load_val (WAIT_L),
      .zero     (cnt_zero)
   );

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      port_d       = port_q;
      we_d         = we_q;
      addr_d       = mem_addr;
      wdata_d      = mem_wdata;
      cs_d         = 1'b0;
      oe_d         = 1'b0;
      wes_d        = 1'b0;
      if_ack_d     = 1'b0;
      ls_ack_d     = 1'b0;
      rdata_en     = 1'b0;
      cnt_load     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (if_req || ls_req) begin
               if (if_req && ls_req) begin
                  port_d = ~last_grant_q;
               end else begin
                  port_d = ls_req ? PORT_LS : PORT_IF;
               end
               // Fetch keeps the previous write data to avoid bus toggling.
               if (port_d == PORT_LS) begin
                  we_d    = ls_we;
                  addr_d  = ls_addr;
                  wdata_d = ls_wdata;
               end else begin
                  we_d    = 1'b0;
                  addr_d  = if_addr;
               end
               cnt_load = 1'b1;
               state_d  = ST_ACCESS;
               cs_d     = 1'b1;
               oe_d     = ~we_d;
               wes_d    = we_d;
            end
         end

         ST_ACCESS: begin
            if (cnt_zero) begin
               state_d      = ST_DONE;
               last_grant_d = port_q;
               rdata_en     = ~we_q;
               if_ack_d     = (port_q == PORT_IF);
               ls_ack_d     = (port_q == PORT_LS);
            end else begin
               cs_d  = 1'b1;
               oe_d  = ~we_q;
               wes_d = we_q;
            end
         end

         ST_DONE: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Strobes and acks are computed one cycle ahead so every output is a flop.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         last_grant_q <= PORT_IF;
         port_q       <= PORT_IF;
         we_q         <= 1'b0;
         mem_addr     <= '0;
         mem_wdata    <= '0;
         mem_cs       <= 1'b0;
         mem_oe       <= 1'b0;
         mem_we       <= 1'b0;
         if_ack       <= 1'b0;
         ls_ack       <= 1'b0;
         rdata        <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         port_q       <= port_d;
         we_q         <= we_d;
         mem_addr     <= addr_d;
         mem_wdata    <= wdata_d;
         mem_cs       <= cs_d;
         mem_oe       <= oe_d;
         mem_we       <= wes_d;
         if_ack       <= if_ack_d;
         ls_ack       <= ls_ack_d;
         if (rdata_en) begin
            rdata <= mem_rdata;
         end
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one WAIT=2 instance for the main
// scenarios and one WAIT=0 instance for back-to-back single-cycle accesses.
module tb_mem_port_arbiter;
   import rv523_pkg::*;

   localparam int AW = 16;
   localparam int DW = 32;

   // clock / reset
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // WAIT=2 instance
   logic          if_req = 1'b0, ls_req = 1'b0, ls_we = 1'b0;
   logic [AW-1:0] if_addr = '0, ls_addr = '0;
   logic [DW-1:0] ls_wdata = '0, mem_rdata = '0;
   logic          if_ack, ls_ack, mem_cs, mem_oe, mem_we;
   logic [DW-1:0] rdata, mem_wdata;
   logic [AW-1:0] mem_addr;

   // WAIT=0 instance
   logic          f0_req = 1'b0, f0_ls_req = 1'b0, f0_ls_we = 1'b0;
   logic [AW-1:0] f0_addr = '0, f0_ls_addr = '0;
   logic [DW-1:0] f0_ls_wdata = '0, f0_mem_rdata = '0;
   logic          f0_ack, f0_ls_ack, f0_cs, f0_oe, f0_we;
   logic [DW-1:0] f0_rdata, f0_wdata;
   logic [AW-1:0] f0_mem_addr;

   int errors = 0;
   int checks = 0;
   logic [AW-1:0] exp_q[$];

   mem_port_arbiter #(.AW(AW), .DW(DW), .WAIT(2)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack),
      .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
      .ls_ack(ls_ack), .rdata(rdata),
      .mem_cs(mem_cs), .mem_oe(mem_oe), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   mem_port_arbiter #(.AW(AW), .DW(DW), .WAIT(0)) dut0 (
      .clk(clk), .rst(rst),
      .if_req(f0_req), .if_addr(f0_addr), .if_ack(f0_ack),
      .ls_req(f0_ls_req), .ls_we(f0_ls_we), .ls_addr(f0_ls_addr),
      .ls_wdata(f0_ls_wdata), .ls_ack(f0_ls_ack), .rdata(f0_rdata),
      .mem_cs(f0_cs), .mem_oe(f0_oe), .mem_we(f0_we),
      .mem_addr(f0_mem_addr), .mem_wdata(f0_wdata), .mem_rdata(f0_mem_rdata)
   );

   // driver tasks
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      if_req = 1'b0;
      ls_req = 1'b0;
      rst    = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (if_ack !== 1'b0 || ls_ack !== 1'b0) begin
         errors++;
         $display("FAIL reset_ack if_ack=%b ls_ack=%b exp=0/0", if_ack, ls_ack);
      end
      checks++;
      if (mem_cs !== 1'b0 || mem_oe !== 1'b0 || mem_we !== 1'b0) begin
         errors++;
         $display("FAIL reset_strobes cs=%b oe=%b we=%b exp=000", mem_cs, mem_oe, mem_we);
      end
      checks++;
      if (rdata !== '0 || mem_addr !== '0 || mem_wdata !== '0) begin
         errors++;
         $display("FAIL reset_buses rdata=%h addr=%h wdata=%h exp=0", rdata, mem_addr, mem_wdata);
      end
      checks++;
      if (dut.state_q !== ST_IDLE) begin
         errors++;
         $display("FAIL reset_state got=%0d exp=%0d", dut.state_q, ST_IDLE);
      end
   endtask

   task automatic test_single_fetch();
      logic exp_cs;
      if_req    = 1'b1;
      if_addr   = 16'h0040;
      mem_rdata = 32'hDEADBEEF;
      for (int k = 1; k <= 5; k++) begin
         step();
         exp_cs = (k <= 3);
         checks++;
         if (mem_cs !== exp_cs || mem_oe !== exp_cs) begin
            errors++;
            $display("FAIL fetch_strobe k=%0d cs=%b oe=%b exp=%b", k, mem_cs, mem_oe, exp_cs);
         end
         checks++;
         if (mem_we !== 1'b0) begin
            errors++;
            $display("FAIL fetch_we k=%0d got=%b exp=0", k, mem_we);
         end
         checks++;
         if (if_ack !== (k == 4) || ls_ack !== 1'b0) begin
            errors++;
            $display("FAIL fetch_ack k=%0d if_ack=%b ls_ack=%b exp_if=%b", k, if_ack, ls_ack, (k == 4));
         end
         if (exp_cs) begin
            checks++;
            if (mem_addr !== 16'h0040) begin
               errors++;
               $display("FAIL fetch_addr k=%0d got=%h exp=0040", k, mem_addr);
            end
         end
         if (k == 4) begin
            checks++;
            if (rdata !== 32'hDEADBEEF) begin
               errors++;
               $display("FAIL fetch_rdata got=%h exp=deadbeef", rdata);
            end
            if_req = 1'b0;
         end
      end
   endtask

   task automatic test_store();
      logic exp_we;
      ls_req    = 1'b1;
      ls_we     = 1'b1;
      ls_addr   = 16'h1000;
      ls_wdata  = 32'h12345678;
      mem_rdata = 32'hCAFEF00D;
      for (int k = 1; k <= 5; k++) begin
         step();
         exp_we = (k <= 3);
         checks++;
         if (mem_we !== exp_we || mem_cs !== exp_we || mem_oe !== 1'b0) begin
            errors++;
            $display("FAIL store_strobe k=%0d cs=%b we=%b oe=%b exp_we=%b", k, mem_cs, mem_we, mem_oe, exp_we);
         end
         checks++;
         if (ls_ack !== (k == 4) || if_ack !== 1'b0) begin
            errors++;
            $display("FAIL store_ack k=%0d ls_ack=%b if_ack=%b exp_ls=%b", k, ls_ack, if_ack, (k == 4));
         end
         if (exp_we) begin
            checks++;
            if (mem_addr !== 16'h1000 || mem_wdata !== 32'h12345678) begin
               errors++;
               $display("FAIL store_bus k=%0d addr=%h wdata=%h exp=1000/12345678", k, mem_addr, mem_wdata);
            end
         end
         if (k == 4) begin
            checks++;
            if (rdata !== 32'hDEADBEEF) begin
               errors++;
               $display("FAIL store_rdata got=%h exp=deadbeef", rdata);
            end
            ls_req = 1'b0;
            ls_we  = 1'b0;
         end
      end
   endtask

   task automatic test_contention();
      logic [AW-1:0] exp_addr;
      do_reset();
      if_addr = 16'h0A00;
      ls_addr = 16'h0B00;
      ls_we   = 1'b0;
      exp_q   = '{16'h0B00, 16'h0A00, 16'h0B00, 16'h0A00};
      if_req  = 1'b1;
      ls_req  = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         step();
         checks++;
         if (ls_ack !== (k == 4 || k == 14) || if_ack !== (k == 9 || k == 19)) begin
            errors++;
            $display("FAIL contend_ack k=%0d if_ack=%b ls_ack=%b", k, if_ack, ls_ack);
         end
         if (if_ack || ls_ack) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL contend_extra_ack k=%0d got=ack exp=none", k);
            end else begin
               exp_addr = exp_q.pop_front();
               if (mem_addr !== exp_addr) begin
                  errors++;
                  $display("FAIL contend_order k=%0d addr=%h exp=%h", k, mem_addr, exp_addr);
               end
            end
         end
         if (k == 19) begin
            if_req = 1'b0;
            ls_req = 1'b0;
         end
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL contend_missing left=%0d exp=0", exp_q.size());
      end
   endtask

   task automatic test_reset_mid_access();
      do_reset();
      if_req    = 1'b1;
      if_addr   = 16'h0200;
      mem_rdata = 32'h11112222;
      step();
      step();
      rst    = 1'b1;
      if_req = 1'b0;
      step();
      rst = 1'b0;
      checks++;
      if (mem_cs !== 1'b0 || mem_oe !== 1'b0 || mem_we !== 1'b0 || dut.state_q !== ST_IDLE) begin
         errors++;
         $display("FAIL midrst_drop cs=%b oe=%b we=%b state=%0d exp=0/0/0/IDLE",
                  mem_cs, mem_oe, mem_we, dut.state_q);
      end
      for (int k = 1; k <= 4; k++) begin
         step();
         checks++;
         if (if_ack !== 1'b0 || ls_ack !== 1'b0 || mem_cs !== 1'b0) begin
            errors++;
            $display("FAIL midrst_quiet k=%0d if_ack=%b ls_ack=%b cs=%b exp=0", k, if_ack, ls_ack, mem_cs);
         end
      end
      if_req    = 1'b1;
      if_addr   = 16'h0300;
      mem_rdata = 32'h0BADC0DE;
      for (int k = 1; k <= 4; k++) begin
         step();
         checks++;
         if (if_ack !== (k == 4) || mem_cs !== (k <= 3)) begin
            errors++;
            $display("FAIL midrst_fresh k=%0d if_ack=%b cs=%b", k, if_ack, mem_cs);
         end
      end
      checks++;
      if (rdata !== 32'h0BADC0DE) begin
         errors++;
         $display("FAIL midrst_rdata got=%h exp=0badc0de", rdata);
      end
      if_req = 1'b0;
      step();
   endtask

   task automatic test_back_to_back_wait0();
      logic          exp_ack, exp_cs;
      logic [AW-1:0] cur_addr;
      int            n;
      n            = 0;
      cur_addr     = 16'h0010;
      f0_addr      = cur_addr;
      f0_mem_rdata = {16'h5A5A, cur_addr};
      f0_req       = 1'b1;
      for (int k = 1; k <= 9; k++) begin
         step();
         exp_ack = ((k % 3) == 2);
         exp_cs  = ((k % 3) == 1);
         checks++;
         if (f0_ack !== exp_ack || f0_cs !== exp_cs || f0_oe !== exp_cs) begin
            errors++;
            $display("FAIL w0_timing k=%0d ack=%b cs=%b oe=%b exp_ack=%b exp_cs=%b",
                     k, f0_ack, f0_cs, f0_oe, exp_ack, exp_cs);
         end
         if (exp_cs) begin
            checks++;
            if (f0_mem_addr !== cur_addr) begin
               errors++;
               $display("FAIL w0_addr k=%0d got=%h exp=%h", k, f0_mem_addr, cur_addr);
            end
         end
         if (exp_ack) begin
            checks++;
            if (f0_rdata !== {16'h5A5A, cur_addr}) begin
               errors++;
               $display("FAIL w0_rdata k=%0d got=%h exp=%h", k, f0_rdata, {16'h5A5A, cur_addr});
            end
            n++;
            if (n < 3) begin
               cur_addr     = cur_addr + 16'h0010;
               f0_addr      = cur_addr;
               f0_mem_rdata = {16'h5A5A, cur_addr};
            end else begin
               f0_req = 1'b0;
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_fetch();
      test_store();
      test_contention();
      test_reset_mid_access();
      test_back_to_back_wait0();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
